// File: rtl/bitop_pkg.sv
// Shared definitions for the bitop_pipe datapath: operation codes and the
// width of the delivered-result counter.
package bitop_pkg;

  typedef enum logic [1:0] {
    OP_NOT = 2'd0,
    OP_AND = 2'd1,
    OP_OR  = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  localparam int XFER_CNT_W = 16;

endpackage : bitop_pkg

// File: rtl/bitop_stage.sv
// One register stage of the bitop pipe: a valid bit and a data word that load
// from upstream whenever the downstream chain allows, and hold otherwise.
module bitop_stage
  import bitop_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             can_load,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  // NOTE: hold values are assigned first so every path writes v_d/d_d and no latch is inferred.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (can_load) begin
      v_d = up_valid;
      d_d = up_data;
    end
  end

  // NOTE: non-blocking assignments keep all stages updating from the same pre-edge values.
  // NOTE: the data word is reset too so out_data reads zero straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v = v_q;
  assign d = d_q;

endmodule : bitop_stage

// File: rtl/bitop_pipe.sv
// WIDTH-bit NOT/AND/OR/XOR unit followed by a DEPTH-stage valid/ready pipe
// with full throughput, backpressure and a wrapping delivery counter.
module bitop_pipe
  import bitop_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [WIDTH-1:0]      in_mask,
  input  logic [1:0]            in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [XFER_CNT_W-1:0] xfer_count
);

  op_e              op;
  logic [WIDTH-1:0] op_result;
  logic [DEPTH-1:0] v_w;
  logic [DEPTH-1:0] can_load;
  logic [WIDTH-1:0] d_w [DEPTH];

  logic [XFER_CNT_W-1:0] xfer_count_q, xfer_count_d;

  assign op = op_e'(in_op);

  always_comb begin
    op_result = '0;
    unique case (op)
      OP_NOT: op_result = ~in_data;
      OP_AND: op_result = in_data & in_mask;
      OP_OR:  op_result = in_data | in_mask;
      OP_XOR: op_result = in_data ^ in_mask;
      default: op_result = '0;
    endcase
  end

  // A stage may load if it is empty or its contents move on this cycle; the
  // chain runs combinationally from out_ready back to in_ready (no skid buffer).
  always_comb begin
    can_load = '0;
    can_load[DEPTH-1] = !v_w[DEPTH-1] || out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      can_load[k] = !v_w[k] || can_load[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      bitop_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .up_valid (in_valid),
        .up_data  (op_result),
        .can_load (can_load[k]),
        .v        (v_w[k]),
        .d        (d_w[k])
      );
    end else begin : g_rest
      bitop_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .up_valid (v_w[k-1]),
        .up_data  (d_w[k-1]),
        .can_load (can_load[k]),
        .v        (v_w[k]),
        .d        (d_w[k])
      );
    end
  end

  always_comb begin
    xfer_count_d = xfer_count_q;
    if (out_valid && out_ready) begin
      xfer_count_d = xfer_count_q + XFER_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count_q <= '0;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

  assign in_ready   = can_load[0];
  assign out_valid  = v_w[DEPTH-1];
  assign out_data   = d_w[DEPTH-1];
  assign xfer_count = xfer_count_q;

endmodule : bitop_pipe

// File: tb/tb_bitop_pipe.sv
// Randomised self-checking bench for bitop_pipe against a queue-based model
// that tracks each accepted word and the edges elapsed since its acceptance.
module tb_bitop_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic        ir;
    logic        ov;
    logic [7:0]  od;
    logic [15:0] cnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [7:0]  in_mask = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [15:0] xfer_count;

  int checks = 0;
  int errors = 0;

  // Reference model: words in flight, oldest first, with their age in edges.
  logic [7:0]  q_data [$];
  int          q_age  [$];
  logic [15:0] m_cnt = '0;

  bitop_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mask    (in_mask),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] op_ref(input logic [1:0] op, input logic [7:0] d,
                                        input logic [7:0] m);
    case (op)
      2'd0:    return ~d;
      2'd1:    return d & m;
      2'd2:    return d | m;
      default: return d ^ m;
    endcase
  endfunction

  // Drives one cycle, samples the DUT at the falling edge, predicts from the
  // model, then advances the model across the rising edge.
  task automatic cycle(input logic iv, input logic [7:0] id, input logic [7:0] im,
                       input logic [1:0] op, input logic ordy, input logic r,
                       output obs_t o, output obs_t e, output obs_t om, output obs_t em,
                       output logic acc, output logic dlv);
    rst = r; in_valid = iv; in_data = id; in_mask = im; in_op = op; out_ready = ordy;
    @(negedge clk);
    o = '{ir: in_ready, ov: out_valid, od: out_data, cnt: xfer_count};
    e.ir  = (q_data.size() < DEPTH) || ordy;
    e.ov  = (q_data.size() > 0) && (q_age[0] >= DEPTH - 1);
    e.od  = e.ov ? q_data[0] : 8'h00;
    e.cnt = m_cnt;
    om = o; em = e;
    if (!e.ov) om.od = 8'h00;
    acc = iv && e.ir && !r;
    dlv = e.ov && ordy && !r;
    @(posedge clk);
    if (r) begin
      q_data.delete(); q_age.delete(); m_cnt = '0;
    end else begin
      foreach (q_age[i]) if (q_age[i] < DEPTH) q_age[i]++;
      if (dlv) begin
        void'(q_data.pop_front()); void'(q_age.pop_front()); m_cnt++;
      end
      if (acc) begin
        q_data.push_back(op_ref(op, id, im)); q_age.push_back(0);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    obs_t o, e, om, em; logic acc, dlv;
    for (int i = 0; i < 2; i++) cycle(1'b1, 8'h3C, 8'hFF, 2'd1, 1'b1, 1'b1, o, e, om, em, acc, dlv);
    cycle(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, o, e, om, em, acc, dlv);
    checks++;
    if (o !== obs_t'{ir: 1'b1, ov: 1'b0, od: 8'h00, cnt: 16'h0000}) begin
      errors++;
      $display("FAIL reset_state got ir=%b ov=%b od=%h cnt=%h want ir=1 ov=0 od=00 cnt=0000",
               o.ir, o.ov, o.od, o.cnt);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, o, e, om, em, acc, dlv);
      checks++;
      if (o.ov !== 1'b0 || o.cnt !== 16'h0000) begin
        errors++;
        $display("FAIL reset_no_accept got ov=%b cnt=%h want ov=0 cnt=0000", o.ov, o.cnt);
      end
    end
  endtask

  task automatic test_all_ops();
    obs_t o, e, om, em; logic acc, dlv;
    logic [7:0] got [$];
    logic [7:0] want [4];
    int first_valid = -1;
    want[0] = 8'h5A; want[1] = 8'h05; want[2] = 8'hAF; want[3] = 8'hAA;
    for (int c = 0; c < 10; c++) begin
      cycle(c < 4, 8'hA5, 8'h0F, 2'(c), 1'b1, 1'b0, o, e, om, em, acc, dlv);
      checks++;
      if (om !== em) begin
        errors++;
        $display("FAIL ops_cycle%0d got %h want %h", c, om, em);
      end
      if (o.ov && first_valid < 0) first_valid = c;
      if (o.ov) got.push_back(o.od);
    end
    checks++;
    if (first_valid !== 2) begin
      errors++;
      $display("FAIL ops_latency got first valid cycle %0d want 2", first_valid);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== want[i]) begin
        errors++;
        $display("FAIL ops_result%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, want[i]);
      end
    end
    checks++;
    if (o.cnt !== 16'd4) begin
      errors++;
      $display("FAIL ops_count got %0d want 4", o.cnt);
    end
  endtask

  task automatic test_backpressure();
    obs_t o, e, om, em; logic acc, dlv;
    logic pat [4];
    int sent = 0, got_n = 0, occ;
    logic prev_stall = 1'b0;
    logic [7:0] prev_od = '0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int c = 0; c < 80 && got_n < 10; c++) begin
      occ = q_data.size();
      cycle(sent < 10, 8'(sent), $urandom, 2'd0, pat[c%4], 1'b0, o, e, om, em, acc, dlv);
      checks++;
      if (om !== em) begin
        errors++;
        $display("FAIL bp_cycle%0d got %h want %h", c, om, em);
      end
      if (prev_stall && o.ov) begin
        checks++;
        if (o.od !== prev_od) begin
          errors++;
          $display("FAIL bp_stable got %h want %h", o.od, prev_od);
        end
      end
      if (occ == DEPTH && !pat[c%4]) begin
        checks++;
        if (o.ir !== 1'b0) begin
          errors++;
          $display("FAIL bp_full_ready got %b want 0", o.ir);
        end
      end
      if (o.ov && pat[c%4]) begin
        checks++;
        if (o.od !== 8'hFF - 8'(got_n)) begin
          errors++;
          $display("FAIL bp_order got %h want %h", o.od, 8'hFF - 8'(got_n));
        end
        got_n++;
      end
      if (acc) sent++;
      prev_stall = o.ov && !pat[c%4];
      prev_od = o.od;
    end
    checks++;
    if (got_n != 10) begin
      errors++;
      $display("FAIL bp_timeout got %0d deliveries want 10", got_n);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o, e, om, em; logic acc, dlv;
    for (int c = 0; c < 10 && q_data.size() < DEPTH; c++)
      cycle(1'b1, $urandom, $urandom, 2'($urandom), 1'b0, 1'b0, o, e, om, em, acc, dlv);
    for (int c = 0; c < 20; c++) begin
      cycle(1'b1, $urandom, $urandom, 2'($urandom), 1'b1, 1'b0, o, e, om, em, acc, dlv);
      checks++;
      if (om !== em || !o.ir || !o.ov || q_data.size() != DEPTH) begin
        errors++;
        $display("FAIL b2b_cycle%0d got %h occ=%0d want %h ir=1 ov=1 occ=%0d",
                 c, om, q_data.size(), em, DEPTH);
      end
    end
  endtask

  task automatic test_random();
    obs_t o, e, om, em; logic acc, dlv;
    for (int c = 0; c < 400; c++) begin
      cycle(($urandom % 4) != 0, $urandom, $urandom, 2'($urandom), ($urandom % 3) != 0, 1'b0,
            o, e, om, em, acc, dlv);
      checks++;
      if (om !== em) begin
        errors++;
        $display("FAIL rand_cycle%0d got %h want %h", c, om, em);
      end
    end
  endtask

  task automatic test_wrap_and_mid_reset();
    obs_t o, e, om, em; logic acc, dlv;
    int sent = 0, got_n = 0;
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, o, e, om, em, acc, dlv);
    for (int c = 0; c < 70000 && got_n < 65537; c++) begin
      cycle(sent < 65537, $urandom, $urandom, 2'($urandom), 1'b1, 1'b0, o, e, om, em, acc, dlv);
      checks++;
      if (om !== em) begin
        errors++;
        $display("FAIL wrap_cycle%0d got %h want %h", c, om, em);
      end
      if (acc) sent++;
      if (o.ov) got_n++;
    end
    cycle(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, o, e, om, em, acc, dlv);
    checks++;
    if (got_n != 65537 || o.cnt !== 16'h0001) begin
      errors++;
      $display("FAIL wrap_count got %h after %0d deliveries want 0001 after 65537", o.cnt, got_n);
    end
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 8'h11 + 8'(i), 8'h00, 2'd0, 1'b0, 1'b0, o, e, om, em, acc, dlv);
    cycle(1'b1, 8'h77, 8'h00, 2'd0, 1'b1, 1'b1, o, e, om, em, acc, dlv);
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, o, e, om, em, acc, dlv);
      checks++;
      if (o.ov !== 1'b0 || o.cnt !== 16'h0000) begin
        errors++;
        $display("FAIL midreset_cycle%0d got ov=%b cnt=%h want ov=0 cnt=0000", c, o.ov, o.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_ops();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_wrap_and_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bitop_pipe
